// File: rtl/pwm_multi_pkg.sv
// Shared types, default build constants and prescaler sizing for the multi-channel PWM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_multi_pkg;

   localparam int CLK_FREQ = 48_000_000;
   localparam int PWM_FREQ = 20_000;
   localparam int PWM_RES  = 8;
   localparam int PWM_NCH  = 4;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   // Clocks per counter step; centre mode counts both ways so it needs half the divide.
   function automatic int calc_div(input int clk_freq, input int freq,
                                   input int nbits, input int center);
      int d;
      if (center != 0)
         d = clk_freq / (freq << (nbits + 1));
      else
         d = clk_freq / (freq << nbits);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/pwm_multi_tick_div.sv
// Prescaler: emits a one-clk tick every div enabled clocks.
// Latency: tick is combinational from the registered prescaler count.
// Backpressure: en = 0 freezes the count and suppresses tick.
module tick_div #(
   parameter int div = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int W = $clog2(div + 1);
   localparam logic [W-1:0] LAST = W'(div - 1);

   logic [W-1:0] pcnt;

   assign tick = en & (pcnt == LAST);

   // Count enabled clocks modulo div; hold while disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pcnt <= '0;
      else if (en) begin
         if (pcnt == LAST)
            pcnt <= '0;
         else
            pcnt <= pcnt + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared prescaler/counter and double-buffered per-channel duties.
// Latency: out is registered one clk after cnt; period pulses in the clk cnt returns to 0.
// Backpressure: none; en = 0 freezes the timebase and forces out low, writes still accepted.
module pwm_multi
   import pwm_multi_pkg::*;
#(
   parameter int clk_freq = CLK_FREQ,
   parameter int freq     = PWM_FREQ,
   parameter int nbits    = PWM_RES,
   parameter int nch      = PWM_NCH,
   parameter int center   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [nch-1:0]       wr,
   input  logic [nch*nbits-1:0] in,
   output logic [nch-1:0]       out,
   output logic                 period
);

   localparam int DIV = calc_div(clk_freq, freq, nbits, center);
   localparam logic [nbits-1:0] MAX = '1;
   localparam logic [nbits-1:0] ONE = nbits'(1);

   logic             tick;
   logic [nbits-1:0] cnt;
   dir_t             dir;
   logic             boundary;
   logic [nch-1:0]   out_nxt;

   tick_div #(.div(DIV)) u_tick_div (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );

   // Boundary is the tick that brings cnt back to 0 (wrap, or end of the down slope).
   always_comb begin
      boundary = 1'b0;
      if (tick) begin
         if (center == 0)
            boundary = (cnt == MAX);
         else
            boundary = (dir == DIR_DOWN) && (cnt == ONE);
      end
   end

   // Shared period counter: sawtooth in edge mode, triangle 0..max..1 in centre mode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         dir <= DIR_UP;
      end else if (tick) begin
         if (center == 0) begin
            cnt <= cnt + 1'b1;
         end else if (dir == DIR_UP) begin
            if (cnt == MAX) begin
               cnt <= MAX - 1'b1;
               dir <= DIR_DOWN;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= cnt - 1'b1;
            if (cnt == ONE)
               dir <= DIR_UP;
         end
      end
   end

   // Period strobe marks the clk in which the freshly loaded duties take effect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         period <= 1'b0;
      else
         period <= boundary;
   end

   for (genvar k = 0; k < nch; k++) begin : g_ch
      logic [nbits-1:0] shadow;
      logic [nbits-1:0] active;

      // Shadow takes writes any time; active only reloads at the boundary, seeing the pre-write shadow.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            shadow <= '0;
            active <= '0;
         end else begin
            if (wr[k])
               shadow <= in[k*nbits +: nbits];
            if (boundary)
               active <= shadow;
         end
      end

      // Full-scale duty is forced high so the top count does not produce a one-step low runt.
      assign out_nxt[k] = en & ((active == MAX) | (cnt < active));
   end

   // Registered outputs so the pins never see compare glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         out <= '0;
      else
         out <= out_nxt;
   end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: one edge-aligned and one centre-aligned instance against a tick-count model.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: n/a.
module tb_pwm_multi;

   localparam int NB = 4;
   localparam int NC = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic [NC-1:0]   wr_e, wr_c;
   logic [NC*NB-1:0] in_e, in_c;
   logic [NC-1:0]   out_e, out_c;
   logic            per_e, per_c;

   always #5 clk = ~clk;

   pwm_multi #(.clk_freq(3200), .freq(100), .nbits(NB), .nch(NC), .center(0)) u_edge (
      .clk(clk), .rst(rst), .en(en), .wr(wr_e), .in(in_e), .out(out_e), .period(per_e));

   pwm_multi #(.clk_freq(3200), .freq(100), .nbits(NB), .nch(NC), .center(1)) u_ctr (
      .clk(clk), .rst(rst), .en(en), .wr(wr_c), .in(in_c), .out(out_c), .period(per_c));

   int vectors = 0;
   int miscompares = 0;

   // Reference: instance 0 = edge (div 2, 16 steps), instance 1 = centre (div 1, 30 steps).
   int div_c[2] = '{2, 1};
   int len_c[2] = '{16, 30};
   int n[2];
   int sh[2][NC];
   int ac[2][NC];
   int eo[2];
   int ep[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Counter value after n enabled clocks, from tick count alone.
   function automatic int cnt_of(input int i, input int nn);
      int t, p;
      t = nn / div_c[i];
      if (i == 0) return t % 16;
      p = t % 30;
      return (p <= 15) ? p : 30 - p;
   endfunction

   function automatic bit will_bound(input int i);
      return en && (((n[i] + 1) / div_c[i]) / len_c[i] > (n[i] / div_c[i]) / len_c[i]);
   endfunction

   task automatic model_reset_one(input int i);
      n[i] = 0; eo[i] = 0; ep[i] = 0;
      for (int k = 0; k < NC; k++) begin
         sh[i][k] = 0;
         ac[i][k] = 0;
      end
   endtask

   task automatic model_reset();
      model_reset_one(0);
      model_reset_one(1);
   endtask

   task automatic model_edge(input int i, input logic [NC-1:0] w, input logic [NC*NB-1:0] d);
      int c, o;
      if (rst) begin
         model_reset_one(i);
         return;
      end
      c = cnt_of(i, n[i]);
      o = 0;
      for (int k = 0; k < NC; k++)
         if (en && (ac[i][k] == 15 || c < ac[i][k])) o |= (1 << k);
      eo[i] = o;
      ep[i] = 0;
      if (en) begin
         if (will_bound(i)) begin
            ep[i] = 1;
            for (int k = 0; k < NC; k++) ac[i][k] = sh[i][k];
         end
         n[i]++;
      end
      for (int k = 0; k < NC; k++)
         if (w[k]) sh[i][k] = int'(d[k*NB +: NB]);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0, wr_e, in_e);
      model_edge(1, wr_c, in_c);
      #1;
      chk("out_e", 32'(out_e), 32'(eo[0]));
      chk("period_e", 32'(per_e), 32'(ep[0]));
      chk("out_c", 32'(out_c), 32'(eo[1]));
      chk("period_c", 32'(per_c), 32'(ep[1]));
   endtask

   task automatic wait_bound(input int i, input string tag);
      int k = 0;
      do begin
         step();
         k++;
      end while (!ep[i] && k < 200);
      chk(tag, 32'(ep[i]), 32'd1);
   endtask

   task automatic wait_cnt(input int v, input string tag);
      int k = 0;
      while (cnt_of(0, n[0]) != v && k < 100) begin
         step();
         k++;
      end
      chk(tag, 32'(cnt_of(0, n[0])), 32'(v));
   endtask

   task automatic count_hi(input int i, input int ch, input int cycles, output int hi, output int pers);
      hi = 0;
      pers = 0;
      for (int j = 0; j < cycles; j++) begin
         step();
         hi   += (i == 0) ? int'(out_e[ch]) : int'(out_c[ch]);
         pers += (i == 0) ? int'(per_e) : int'(per_c);
      end
   endtask

   initial begin
      int hi, pp, k;
      rst = 1'b1; en = 1'b0;
      wr_e = '0; wr_c = '0; in_e = '0; in_c = '0;
      model_reset();
      #1;
      chk("rst_out_e", 32'(out_e), 32'd0);
      chk("rst_period_e", 32'(per_e), 32'd0);
      repeat (3) step();
      rst = 1'b0;
      en  = 1'b1;

      // Basic duty: ch0 = 4, ch1 = 0 on edge; ch0 = 4 on centre.
      wr_e = 2'b11; in_e = {4'd0, 4'd4};
      wr_c = 2'b01; in_c = {4'd0, 4'd4};
      step();
      wr_e = '0; wr_c = '0;
      wait_bound(0, "t1_bound");
      count_hi(0, 0, 32, hi, pp);
      chk("t1_hi_ch0", 32'(hi), 32'd8);
      chk("t1_period_cnt", 32'(pp), 32'd1);
      count_hi(0, 1, 32, hi, pp);
      chk("t1_hi_ch1", 32'(hi), 32'd0);
      wait_bound(1, "t6_bound");
      count_hi(1, 0, 30, hi, pp);
      chk("t6_hi_centre", 32'(hi), 32'd7);
      chk("t6_period_cnt", 32'(pp), 32'd1);

      // Full-scale duty stays high across periods.
      in_e[3:0] = 4'd15; wr_e = 2'b01;
      step();
      wr_e = '0;
      wait_bound(0, "t2_bound");
      count_hi(0, 0, 64, hi, pp);
      chk("t2_hi_max", 32'(hi), 32'd64);

      // Mid-period write only lands at the next boundary.
      wait_cnt(5, "t3_cnt5");
      in_e[3:0] = 4'd8; wr_e = 2'b01;
      step();
      wr_e = '0;
      wait_bound(0, "t3_bound");
      count_hi(0, 0, 32, hi, pp);
      chk("t3_hi_half", 32'(hi), 32'd16);

      // Write coincident with the boundary is deferred a full period.
      k = 0;
      while (!will_bound(0) && k < 100) begin
         step();
         k++;
      end
      chk("t3_sync", 32'(will_bound(0)), 32'd1);
      in_e[3:0] = 4'd4; wr_e = 2'b01;
      step();
      wr_e = '0;
      chk("t3_coinc_period", 32'(per_e), 32'd1);
      count_hi(0, 0, 32, hi, pp);
      chk("t3_coinc_old", 32'(hi), 32'd16);
      count_hi(0, 0, 32, hi, pp);
      chk("t3_coinc_new", 32'(hi), 32'd8);

      // Disable mid-high: outputs low, no strobes, then resume.
      wait_cnt(1, "t4_cnt1");
      en = 1'b0;
      count_hi(0, 0, 50, hi, pp);
      chk("t4_hi_off", 32'(hi), 32'd0);
      chk("t4_period_off", 32'(pp), 32'd0);
      en = 1'b1;
      wait_bound(0, "t4_bound");
      count_hi(0, 0, 64, hi, pp);
      chk("t4_hi_resume", 32'(hi), 32'd16);

      // Async reset mid-period.
      wait_cnt(7, "t5_cnt7");
      rst = 1'b1;
      model_reset();
      #1;
      chk("t5_async_out_e", 32'(out_e), 32'd0);
      chk("t5_async_out_c", 32'(out_c), 32'd0);
      chk("t5_async_period", 32'(per_e), 32'd0);
      repeat (3) step();
      rst = 1'b0;
      count_hi(0, 0, 40, hi, pp);
      chk("t5_hi_after_rst", 32'(hi), 32'd0);

      // Randomised writes, enable toggles and reset pulses against the model.
      for (int r = 0; r < 1500; r++) begin
         wr_e = '0; wr_c = '0;
         for (int c = 0; c < NC; c++) begin
            if ($urandom_range(0, 7) == 0) begin
               wr_e[c] = 1'b1;
               in_e[c*NB +: NB] = NB'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
               wr_c[c] = 1'b1;
               in_c[c*NB +: NB] = NB'($urandom);
            end
         end
         if ($urandom_range(0, 49) == 0) en = ~en;
         if ($urandom_range(0, 399) == 0) begin
            rst = 1'b1;
            model_reset();
            step();
            rst = 1'b0;
         end else begin
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
